regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32-entry register file and shares it between NUM_REQ writeback requesters (e.g. ALU result, load data, link register) using a valid/ready handshake and round-robin arbitration.
- After every reset it first runs a scrub sequence that writes zero to registers 1..NUM_REGISTERS-1, then enters normal arbitration.
- Sits between the writeback sources and the register file's writeRegister/writeData/writeEnable inputs.

Parameters:
- DATA_WIDTH, 32, width of register data.
- NUM_REGISTERS, 32, number of architectural registers; power of two, at most 32.
- NUM_REQ, 3, number of writeback requesters, 2 to 8.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*5  flattened destination register numbers; requester i uses bits [5i+4:5i].
- req_data  input  NUM_REQ*DATA_WIDTH  flattened write data; requester i uses slice i.
- req_ready  output  NUM_REQ  one-hot grant; the request transfers when valid and ready are both high.
- writeRegister  output  5  register-file write address, registered.
- writeData  output  DATA_WIDTH  register-file write data, registered.
- writeEnable  output  1  register-file write enable, registered.
- init_done  output  1  high once the scrub sequence has completed.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - writeEnable=0, writeRegister=0, writeData=0, init_done=0.
  - req_ready=0 (combinational, driven low outside ARB).
  - state=SCRUB, scrub_cnt=1, rr_ptr=0.
- rst has priority over all other activity in any state. Reset asserted mid-scrub or mid-arbitration restarts the scrub from register 1, and any in-flight output write is squashed.
- State SCRUB:
  - Each edge with rst=0 registers writeEnable=1, writeRegister=scrub_cnt, writeData=0, then increments scrub_cnt.
  - On the edge that issues register NUM_REGISTERS-1, the block moves to ARB and sets init_done=1.
  - Scrub therefore takes exactly NUM_REGISTERS-1 cycles. Register 0 is never written.
  - req_ready stays 0 throughout; requesters hold their requests.
- State ARB:
  - Grant goes to the first requester with valid=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready is one-hot for that requester, or all zero if no requester is valid.
  - req_ready is combinational from req_valid and rr_ptr, with no dependency on the register-file outputs.
- Transfer in cycle t:
  - After the edge ending cycle t: writeEnable=1, writeRegister=req_addr[g], writeData=req_data[g].
  - rr_ptr becomes (g+1) mod NUM_REQ.
  - Latency is 1 cycle from accept to the write strobe. The register file commits the write on the next edge, so the data is readable 2 edges after accept.
- No transfer in a cycle: writeEnable=0 on the next edge; writeRegister and writeData hold their previous values; rr_ptr holds.
- Destination register 0: the transfer is accepted (ready asserted normally, rr_ptr advances), but writeEnable is registered as 0.
- Throughput is one write per cycle. Back-to-back transfers from different requesters on consecutive cycles are required.
- Requester rules (verified by bench assertions, not enforced in RTL):
  - Once req_valid[i] is high, it stays high with req_addr and req_data stable until the request is accepted.
- A requester never has ready high without valid in the same cycle.
- init_done stays 1 until the next reset.

Decomposition:
- Package regfile_ctrl_pkg:
  - state enum {SCRUB, ARB};
  - REG_ADDR_WIDTH=5;
  - a function for the rotating priority search.
- Sub-module rr_arbiter: parameter NUM_REQ; inputs req, ptr; output one-hot grant and its index.
  - Purely combinational; the pointer register lives in the parent.
- Parent contains the FSM, scrub counter, rr_ptr and output registers.

Test Plan:
- Scrub: release rst, hold all req_valid=1 -> 31 consecutive strobes writing 0 to registers 1..31 in order, req_ready=0 throughout, init_done rises on edge 31, first grant goes to requester 0.
- Round robin: after init, all three requesters valid with addr 2/3/4 and data 32'h11223344/32'h55667788/32'h99AABBCC -> grants 0,1,2 on consecutive cycles; register file reads back those values.
- Rotation: only requesters 1 and 2 valid continuously -> grants alternate 1,2,1,2; requester 0 never granted; rr_ptr skips requester 0.
- Register 0: requester 0 writes 32'hAABBCCDD to register 0 -> ready high for one cycle, writeEnable stays 0, readData of register 0 remains 32'h00000000.
- Idle and hold: no valid for 5 cycles -> writeEnable=0, writeRegister/writeData unchanged; a later single request to register 7 -> strobe exactly one cycle after accept.
- Reset mid-operation: assert rst during scrub at register 10, and again during ARB with a pending request -> no strobe on the reset edge, init_done=0, scrub restarts at register 1, pending request is not granted until ARB is re-entered.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types and rotating-priority search for the regfile write arbiter
package regfile_ctrl_pkg;

    typedef enum logic {SCRUB, ARB} state_t;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int MAX_REQ        = 8;
    localparam int MAX_IDX_W      = 3;

    // Returns {found, index}: first set bit of req at or above ptr, wrapping modulo num_req.
    function automatic logic [MAX_IDX_W:0] rr_search(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   num_req
    );
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
        int                   cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            cand = (int'(ptr) + k) % num_req;
            if (k < num_req && !found && req[cand[MAX_IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[MAX_IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rtl/regfile_write_arbiter_rr_arbiter.sv - combinational round-robin grant selection
module rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [MAX_IDX_W:0] pick;

    always_comb begin
        pick      = rr_search(MAX_REQ'(req), MAX_IDX_W'(ptr), NUM_REQ);
        grant_idx = IDX_W'(pick[MAX_IDX_W-1:0]);
        grant     = pick[MAX_IDX_W] ? (NUM_REQ'(1'b1) << grant_idx) : '0;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - scrubs the register file after reset, then round-robins its write port
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int NUM_REQ       = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [REG_ADDR_WIDTH-1:0]           writeRegister,
    output logic [DATA_WIDTH-1:0]               writeData,
    output logic                                writeEnable,
    output logic                                init_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [REG_ADDR_WIDTH-1:0] LAST_REG = REG_ADDR_WIDTH'(NUM_REGISTERS - 1);

    state_t                      state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0]   scrub_cnt_q, scrub_cnt_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic                        we_q, we_d;
    logic [REG_ADDR_WIDTH-1:0]   wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic                        init_q, init_d;

    logic [NUM_REQ-1:0]          grant;
    logic [IDX_W-1:0]            grant_idx;
    logic [REG_ADDR_WIDTH-1:0]   g_addr;
    logic [DATA_WIDTH-1:0]       g_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_addr = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                g_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        we_d        = 1'b0;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        init_d      = init_q;
        req_ready   = '0;
        case (state_q)
            SCRUB: begin
                we_d        = 1'b1;
                wreg_d      = scrub_cnt_q;
                wdata_d     = '0;
                scrub_cnt_d = scrub_cnt_q + 1'b1;
                if (scrub_cnt_q == LAST_REG) begin
                    state_d = ARB;
                    init_d  = 1'b1;
                end
            end
            ARB: begin
                // Grant is masked during reset so a pending request is never accepted on a reset edge.
                if (!rst) begin
                    req_ready = grant;
                end
                if (|grant) begin
                    we_d     = (g_addr != '0);
                    wreg_d   = g_addr;
                    wdata_d  = g_data;
                    rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCRUB;
            scrub_cnt_q <= REG_ADDR_WIDTH'(1);
            rr_ptr_q    <= '0;
            we_q        <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
            init_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            we_q        <= we_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            init_q      <= init_d;
        end
    end

    assign writeEnable   = we_q;
    assign writeRegister = wreg_q;
    assign writeData     = wdata_q;
    assign init_done     = init_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized and directed bench against a behavioural write-port model
module tb_regfile_write_arbiter;

    localparam int NREQ  = 3;
    localparam int DW    = 32;
    localparam int NREGS = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*5-1:0]    req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [4:0]           writeRegister;
    logic [DW-1:0]        writeData;
    logic                 writeEnable;
    logic                 init_done;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .NUM_REGISTERS(NREGS), .NUM_REQ(NREQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .writeEnable   (writeEnable),
        .init_done     (init_done)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT write port.
    logic [DW-1:0] rf [NREGS];
    always @(posedge clk) begin
        if (writeEnable) rf[writeRegister] <= writeData;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_hold
            assert property (@(posedge clk) disable iff (rst)
                (req_valid[gi] && !req_ready[gi]) |=>
                (req_valid[gi] && $stable(req_addr[gi*5 +: 5]) && $stable(req_data[gi*DW +: DW])))
            else $error("FAIL hold requester %0d dropped or changed a pending request", gi);
        end
    endgenerate

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Behavioural model: scrub position, pointer, expected registered outputs, expected memory.
    bit            m_arb;
    int            m_scrub;
    int            m_ptr;
    logic          m_we;
    logic          m_init;
    logic [4:0]    m_wreg;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] exp_mem [NREGS];
    logic [NREQ-1:0] last_ready;
    int            strobes;

    task automatic model_reset();
        m_arb = 0; m_scrub = 1; m_ptr = 0;
        m_we = 0; m_init = 0; m_wreg = '0; m_wdata = '0;
    endtask

    task automatic tick();
        int g;
        logic [NREQ-1:0] exp_ready;
        #1;
        g = -1;
        if (!rst && m_arb) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
        last_ready = req_ready;
        check("ready", 64'(req_ready), 64'(exp_ready));
        check("ready_wo_valid", 64'(req_ready & ~req_valid), 64'd0);
        if (m_we) exp_mem[m_wreg] = m_wdata;
        if (rst) begin
            model_reset();
        end else if (!m_arb) begin
            m_we = 1; m_wreg = 5'(m_scrub); m_wdata = '0;
            if (m_scrub == NREGS - 1) begin
                m_arb = 1; m_init = 1;
            end
            m_scrub++;
        end else if (g >= 0) begin
            m_wreg  = req_addr[g*5 +: 5];
            m_wdata = req_data[g*DW +: DW];
            m_we    = (m_wreg != 0);
            m_ptr   = (g + 1) % NREQ;
        end else begin
            m_we = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("writeEnable", 64'(writeEnable), 64'(m_we));
        check("writeRegister", 64'(writeRegister), 64'(m_wreg));
        check("writeData", 64'(writeData), 64'(m_wdata));
        check("init_done", 64'(init_done), 64'(m_init));
        if (writeEnable) strobes++;
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    task automatic post(input int i, input logic [4:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_addr[i*5 +: 5] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            rf[i]      = (i == 0) ? '0 : (32'hDEAD0000 | i);
            exp_mem[i] = rf[i];
        end
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        model_reset();
        @(negedge clk);
        tick(); tick();
        check("reset_init_done", 64'(init_done), 64'd0);
        check("reset_we", 64'(writeEnable), 64'd0);

        // Scrub with all requesters already waiting; then round robin 0,1,2.
        post(0, 5'd2, 32'h11223344);
        post(1, 5'd3, 32'h55667788);
        post(2, 5'd4, 32'h99AABBCC);
        rst = 1'b0;
        strobes = 0;
        for (int k = 0; k < NREGS - 1; k++) tick();
        check("scrub_strobes", 64'(strobes), 64'd31);
        check("scrub_last_reg", 64'(writeRegister), 64'd31);
        check("scrub_init", 64'(init_done), 64'd1);
        tick(); check("rr_first", 64'(last_ready), 64'b001);
        tick(); check("rr_second", 64'(last_ready), 64'b010);
        tick(); check("rr_third", 64'(last_ready), 64'b100);
        tick(); tick();
        check("rf2", 64'(rf[2]), 64'h11223344);
        check("rf3", 64'(rf[3]), 64'h55667788);
        check("rf4", 64'(rf[4]), 64'h99AABBCC);
        for (int r = 5; r < NREGS; r++) check("scrub_zero", 64'(rf[r]), 64'd0);

        // Only requesters 1 and 2 keep requesting.
        for (int k = 0; k < 6; k++) begin
            if (!req_valid[1]) post(1, 5'($urandom_range(1, 31)), $urandom);
            if (!req_valid[2]) post(2, 5'($urandom_range(1, 31)), $urandom);
            tick();
            check("rotation", 64'(last_ready), (k % 2 == 0) ? 64'b010 : 64'b100);
        end
        tick(); tick();

        // Write to register 0 is accepted but suppressed.
        post(0, 5'd0, 32'hAABBCCDD);
        tick();
        check("r0_ready", 64'(last_ready), 64'b001);
        check("r0_we", 64'(writeEnable), 64'd0);
        tick(); tick();
        check("r0_read", 64'(rf[0]), 64'd0);

        // Idle hold, then a single request to register 7.
        for (int k = 0; k < 5; k++) tick();
        post(1, 5'd7, 32'hCAFE0007);
        tick();
        check("r7_strobe", 64'(writeEnable), 64'd1);
        check("r7_reg", 64'(writeRegister), 64'd7);
        tick(); tick();
        check("r7_read", 64'(rf[7]), 64'hCAFE0007);

        // Reset mid-scrub at register 10, with a request pending across it.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 40 && m_scrub != 10; k++) tick();
        post(1, 5'd9, 32'h0BADF00D);
        rst = 1'b1; tick();
        check("mid_scrub_we", 64'(writeEnable), 64'd0);
        rst = 1'b0;
        strobes = 0;
        for (int k = 0; k < NREGS - 1; k++) tick();
        check("rescrub_strobes", 64'(strobes), 64'd31);
        tick(); check("pending_after_scrub", 64'(last_ready), 64'b010);

        // Reset during ARB with a pending request.
        post(2, 5'd12, 32'h12121212);
        rst = 1'b1; tick();
        check("arb_reset_ready", 64'(last_ready), 64'd0);
        check("arb_reset_we", 64'(writeEnable), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < NREGS - 1; k++) tick();
        tick(); check("arb_pending_grant", 64'(last_ready), 64'b100);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    post(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        req_valid = '0;
        tick(); tick();
        for (int r = 0; r < NREGS; r++) check("final_mem", 64'(rf[r]), 64'(exp_mem[r]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
